// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: captures the memory-stage slot, extracts and extends sub-word
// load data, selects writeback data, flags misaligned loads and counts retired instructions.
module mem_wb_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_reg_write,
  input  logic             in_mem_to_reg,
  input  logic [1:0]       in_load_size,
  input  logic             in_load_unsigned,
  input  logic [4:0]       in_write_reg,
  input  logic [31:0]      alu_result,
  input  logic [31:0]      mem_data_out,
  output logic             wb_valid,
  output logic             wb_reg_write,
  output logic [4:0]       wb_write_reg,
  output logic [31:0]      wb_write_data,
  output logic             misalign_err,
  output logic [CNT_W-1:0] retire_count
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  logic [1:0]  addr_lo;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;
  logic [31:0] wb_data_next;
  logic        misaligned;
  logic        reg_write_next;

  assign addr_lo = alu_result[1:0];

  always_comb begin
    byte_lane = 8'h00;
    case (addr_lo)
      2'd0: byte_lane = mem_data_out[7:0];
      2'd1: byte_lane = mem_data_out[15:8];
      2'd2: byte_lane = mem_data_out[23:16];
      2'd3: byte_lane = mem_data_out[31:24];
      default: byte_lane = 8'h00;
    endcase
    half_lane = addr_lo[1] ? mem_data_out[31:16] : mem_data_out[15:0];
  end

  // Reserved size 2'b11 behaves as a full word.
  always_comb begin
    load_data  = mem_data_out;
    misaligned = 1'b0;
    case (in_load_size)
      SIZE_BYTE: begin
        load_data = {{24{byte_lane[7] & ~in_load_unsigned}}, byte_lane};
      end
      SIZE_HALF: begin
        load_data  = {{16{half_lane[15] & ~in_load_unsigned}}, half_lane};
        misaligned = addr_lo[0];
      end
      default: begin
        load_data  = mem_data_out;
        misaligned = (addr_lo != 2'd0);
      end
    endcase
    misaligned     = misaligned & in_valid & in_mem_to_reg;
    wb_data_next   = in_mem_to_reg ? load_data : alu_result;
    reg_write_next = in_valid & in_reg_write & (in_write_reg != 5'd0) & ~misaligned;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_write_reg  <= 5'd0;
      wb_write_data <= 32'd0;
      misalign_err  <= 1'b0;
      retire_count  <= '0;
    end else if (flush) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_write_reg  <= 5'd0;
      wb_write_data <= 32'd0;
      misalign_err  <= 1'b0;
    end else if (stall) begin
      // Hold everything but do not repeat an error pulse.
      misalign_err <= 1'b0;
    end else begin
      wb_valid      <= in_valid;
      wb_reg_write  <= reg_write_next;
      wb_write_reg  <= in_write_reg;
      wb_write_data <= wb_data_next;
      misalign_err  <= misaligned;
      if (in_valid && !misaligned) begin
        retire_count <= retire_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vector table, hand-written multi-cycle
// sequences and randomized traffic compared against an arithmetic reference model.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, in_valid, in_reg_write, in_mem_to_reg;
  logic [1:0]  in_load_size;
  logic        in_load_unsigned;
  logic [4:0]  in_write_reg;
  logic [31:0] alu_result, mem_data_out;

  logic        wb_valid, wb_reg_write, misalign_err;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data, retire_count;

  logic        s_valid, s_reg_write, s_misalign;
  logic [4:0]  s_write_reg;
  logic [31:0] s_write_data;
  logic [3:0]  retire_count4;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic        m_valid, m_rw, m_mis;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;
  longint unsigned m_cnt;

  always #5 clk = ~clk;

  mem_wb_stage #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg), .in_load_size(in_load_size),
    .in_load_unsigned(in_load_unsigned), .in_write_reg(in_write_reg), .alu_result(alu_result),
    .mem_data_out(mem_data_out), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data), .misalign_err(misalign_err),
    .retire_count(retire_count)
  );

  mem_wb_stage #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg), .in_load_size(in_load_size),
    .in_load_unsigned(in_load_unsigned), .in_write_reg(in_write_reg), .alu_result(alu_result),
    .mem_data_out(mem_data_out), .wb_valid(s_valid), .wb_reg_write(s_reg_write),
    .wb_write_reg(s_write_reg), .wb_write_data(s_write_data), .misalign_err(s_misalign),
    .retire_count(retire_count4)
  );

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns,
                                           input int unsigned a, input logic [31:0] mem);
    longint unsigned w, v, bits;
    w = mem;
    if (size == 2'd0) begin
      bits = 8;
      v = (w >> (8 * a)) % 256;
    end else if (size == 2'd1) begin
      bits = 16;
      v = (w >> (16 * (a / 2))) % 65536;
    end else begin
      bits = 32;
      v = w;
    end
    if (!uns && bits < 32 && v >= (64'd1 << (bits - 1)))
      v = v + (64'd1 << 32) - (64'd1 << bits);
    return v[31:0];
  endfunction

  function automatic logic ref_mis();
    int unsigned a;
    a = alu_result % 4;
    if (!(in_valid && in_mem_to_reg)) return 1'b0;
    if (in_load_size == 2'd1) return (a % 2) == 1;
    if (in_load_size >= 2'd2) return a != 0;
    return 1'b0;
  endfunction

  task automatic model_step();
    logic mis;
    if (reset) begin
      m_valid = 0; m_rw = 0; m_wreg = 0; m_wdata = 0; m_mis = 0; m_cnt = 0;
    end else if (flush) begin
      m_valid = 0; m_rw = 0; m_wreg = 0; m_wdata = 0; m_mis = 0;
    end else if (stall) begin
      m_mis = 0;
    end else begin
      mis = ref_mis();
      m_valid = in_valid;
      m_rw = in_valid && in_reg_write && in_write_reg != 0 && !mis;
      m_wreg = in_write_reg;
      m_wdata = in_mem_to_reg ? ref_load(in_load_size, in_load_unsigned, alu_result % 4, mem_data_out)
                              : alu_result;
      m_mis = mis;
      if (in_valid && !mis) m_cnt = m_cnt + 1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock edge and compare every output to the model.
  task automatic apply(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check({tag, ".valid"}, 32'(wb_valid), 32'(m_valid));
    check({tag, ".reg_write"}, 32'(wb_reg_write), 32'(m_rw));
    check({tag, ".write_reg"}, 32'(wb_write_reg), 32'(m_wreg));
    check({tag, ".write_data"}, wb_write_data, m_wdata);
    check({tag, ".misalign"}, 32'(misalign_err), 32'(m_mis));
    check({tag, ".count"}, retire_count, m_cnt[31:0]);
    check({tag, ".count4"}, 32'(retire_count4), 32'(m_cnt % 16));
  endtask

  task automatic set_in(input logic v, input logic rw, input logic m2r, input logic [1:0] sz,
                        input logic uns, input logic [4:0] wr, input logic [31:0] alu,
                        input logic [31:0] mem);
    in_valid = v; in_reg_write = rw; in_mem_to_reg = m2r; in_load_size = sz;
    in_load_unsigned = uns; in_write_reg = wr; alu_result = alu; mem_data_out = mem;
  endtask

  task automatic set_rand();
    set_in(1'($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom), 2'($urandom),
           1'($urandom), 5'($urandom_range(0, 31)), $urandom, $urandom);
  endtask

  typedef struct {
    logic        v, rw, m2r;
    logic [1:0]  sz;
    logic        uns;
    logic [4:0]  wr;
    logic [31:0] alu, mem;
    logic        e_valid, e_rw, e_mis, chk_data;
    logic [31:0] e_data;
    int          e_inc;
  } vec_t;

  vec_t vecs[10];

  initial begin
    longint unsigned cnt_before;
    vecs[0] = '{1,1,1,2'd0,0,5'd5, 32'h1003,32'h8000_0000, 1,1,0,1,32'hFFFF_FF80,1};
    vecs[1] = '{1,1,1,2'd1,1,5'd6, 32'h1002,32'hBEEF_1234, 1,1,0,1,32'h0000_BEEF,1};
    vecs[2] = '{1,1,1,2'd1,0,5'd7, 32'h1001,32'hBEEF_1234, 1,0,1,0,32'h0,0};
    vecs[3] = '{1,1,0,2'd2,0,5'd0, 32'h0000_0055,32'h0, 1,0,0,1,32'h0000_0055,1};
    vecs[4] = '{1,1,1,2'd0,1,5'd8, 32'h1001,32'h1234_5678, 1,1,0,1,32'h0000_0056,1};
    vecs[5] = '{1,1,1,2'd2,0,5'd9, 32'h2000,32'hDEAD_BEEF, 1,1,0,1,32'hDEAD_BEEF,1};
    vecs[6] = '{1,1,1,2'd2,0,5'd9, 32'h2002,32'hDEAD_BEEF, 1,0,1,0,32'h0,0};
    vecs[7] = '{1,1,1,2'd1,0,5'd10,32'h1002,32'h8001_1234, 1,1,0,1,32'hFFFF_8001,1};
    vecs[8] = '{1,1,1,2'd3,0,5'd11,32'h3000,32'hCAFE_F00D, 1,1,0,1,32'hCAFE_F00D,1};
    vecs[9] = '{0,1,0,2'd2,0,5'd12,32'h77,32'h0, 0,0,0,0,32'h0,0};

    reset = 1; stall = 0; flush = 0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    apply("reset0");
    apply("reset1");
    reset = 0;

    foreach (vecs[i]) begin
      set_in(vecs[i].v, vecs[i].rw, vecs[i].m2r, vecs[i].sz, vecs[i].uns, vecs[i].wr,
             vecs[i].alu, vecs[i].mem);
      cnt_before = m_cnt;
      apply($sformatf("vec%0d", i));
      check($sformatf("vec%0d.tbl_valid", i), 32'(wb_valid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d.tbl_rw", i), 32'(wb_reg_write), 32'(vecs[i].e_rw));
      check($sformatf("vec%0d.tbl_mis", i), 32'(misalign_err), 32'(vecs[i].e_mis));
      check($sformatf("vec%0d.tbl_inc", i), retire_count, 32'(cnt_before + vecs[i].e_inc));
      if (vecs[i].chk_data)
        check($sformatf("vec%0d.tbl_data", i), wb_write_data, vecs[i].e_data);
    end

    // stall with changing inputs holds everything
    set_in(1, 1, 0, 2'd2, 0, 5'd3, 32'hA5A5_0001, 0);
    apply("pre_stall");
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_rand();
      apply($sformatf("stall%0d", i));
      check("stall_frozen_data", wb_write_data, 32'hA5A5_0001);
    end
    flush = 1;
    set_rand();
    apply("stall_flush");
    check("stall_flush_valid", 32'(wb_valid), 32'd0);
    stall = 0; flush = 0;

    // misaligned load directly followed by a stall: pulse must not repeat
    set_in(1, 1, 1, 2'd1, 0, 5'd4, 32'h0000_0003, 32'h1111_2222);
    apply("mis_then_stall");
    stall = 1;
    apply("mis_stalled");
    stall = 0;

    // reset held two cycles mid-stream
    set_in(1, 1, 0, 2'd2, 0, 5'd2, 32'h10, 0);
    apply("pre_reset");
    reset = 1;
    apply("mid_reset0");
    apply("mid_reset1");
    check("mid_reset_count", retire_count, 32'd0);
    reset = 0;

    // 17 retirements: 4-bit counter wraps 15 -> 0 and reads 1
    for (int i = 0; i < 17; i++) begin
      set_in(1, 0, 0, 2'd0, 0, 5'd1, 32'(i), 0);
      apply($sformatf("wrap%0d", i));
    end
    check("wrap_small_count", 32'(retire_count4), 32'd1);
    check("wrap_full_count", retire_count, 32'd17);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 99) < 2);
      flush = ($urandom_range(0, 99) < 6);
      stall = ($urandom_range(0, 99) < 12);
      set_rand();
      apply("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
